// File: rtl/chunked_adder.sv
// chunked_adder
//   Multi-cycle adder/subtractor that processes CHUNK bits per clock, starting
//   from the least-significant slice, until all WIDTH bits are done.
//   Operands are captured when a request is accepted, so input changes during
//   an operation have no effect on it.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : operation request, accepted only in IDLE
//   a, b   : operands (WIDTH bits)
//   cin    : carry-in, add mode only
//   sub    : 0 = a+b+cin, 1 = a-b
//   busy   : high while slices are being computed
//   done   : one-cycle pulse when sum/cout/ovf have been updated
//   sum    : result (modulo 2^WIDTH)
//   cout   : carry out of the top bit (subtract: 1 = no borrow)
//   ovf    : two's-complement overflow

module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH  = WIDTH / CHUNK;
    // A one-chunk configuration still needs a 1-bit index register.
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] next_work;
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_s;
    logic [CHUNK:0]   chunk_res;
    logic             last_chunk;
    logic             top_ovf;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status outputs
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_chunk) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Slice adder for the current chunk. The working register image that
    // includes this cycle's slice is formed here so the final edge can move
    // the complete result to sum in one step.
    always_comb begin
        slice_a    = op_a[idx*CHUNK +: CHUNK];
        slice_b    = op_b[idx*CHUNK +: CHUNK];
        chunk_res  = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry};
        slice_s    = chunk_res[CHUNK-1:0];
        next_work  = work;
        next_work[idx*CHUNK +: CHUNK] = slice_s;
        last_chunk = (idx == LAST_IDX);
        // The carry into the MSB equals a^b^s at that bit; XOR with the carry
        // out gives overflow, and this works for any CHUNK including 1.
        top_ovf    = slice_a[CHUNK-1] ^ slice_b[CHUNK-1] ^ slice_s[CHUNK-1]
                   ^ chunk_res[CHUNK];
    end

    // Operand capture, slice iteration and result transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    work  <= next_work;
                    carry <= chunk_res[CHUNK];
                    if (last_chunk) begin
                        idx  <= '0;
                        sum  <= next_work;
                        cout <= chunk_res[CHUNK];
                        ovf  <= top_ovf;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder
//   Self-checking bench for chunked_adder. Three instances: the default
//   16/4 configuration for directed and protocol tests, plus 8/8 and 32/1
//   for randomized parameter coverage. Expected results are pushed to a
//   per-instance queue when a request is driven and popped on done.

module tb_chunked_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          stamp;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    // 16-bit, 4-bit chunks
    logic        start16, cin16, sub16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    // 8-bit, single chunk
    logic        start8, cin8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    // 32-bit, 1-bit chunks
    logic        start32, cin32, sub32, busy32, done32, cout32, ovf32;
    logic [31:0] a32, b32, sum32;

    exp_t q16[$];
    exp_t q8[$];
    exp_t q32[$];

    logic [15:0] cur_sum;
    logic [15:0] prev_sum;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .cin(cin16), .sub(sub16), .busy(busy16), .done(done16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    chunked_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .busy(busy8), .done(done8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    chunked_adder #(.WIDTH(32), .CHUNK(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .busy(busy32), .done(done32),
        .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference model: wide integer add, overflow from operand/result signs.
    function automatic exp_t model(int w, logic [31:0] ta, logic [31:0] tb,
                                   logic tcin, logic tsub, int stamp);
        logic [63:0] mask;
        logic [63:0] bb;
        logic [63:0] full;
        exp_t        e;
        mask = (64'd1 << w) - 64'd1;
        bb   = tsub ? (~{32'd0, tb}) & mask : {32'd0, tb};
        full = {32'd0, ta} + bb + (tsub ? 64'd1 : {63'd0, tcin});
        e.sum  = 32'(full & mask);
        e.cout = full[w];
        if (tsub)
            e.ovf = (ta[w-1] != tb[w-1]) && (e.sum[w-1] != ta[w-1]);
        else
            e.ovf = (ta[w-1] == tb[w-1]) && (e.sum[w-1] != ta[w-1]);
        e.stamp = stamp;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one request on the 16-bit instance from an IDLE negedge.
    // stamp is taken one edge before acceptance, so latency to done
    // is NCH+1 cycles from the request.
    task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                                 input logic tcin, input logic tsub);
        exp_t e;
        a16     = ta;
        b16     = tb;
        cin16   = tcin;
        sub16   = tsub;
        start16 = 1'b1;
        e = model(16, {16'd0, ta}, {16'd0, tb}, tcin, tsub, cyc);
        q16.push_back(e);
        prev_sum = cur_sum;
        cur_sum  = e.sum[15:0];
        @(negedge clk);
        start16 = 1'b0;
    endtask

    // Wait for done on the 16-bit instance, then step into the IDLE cycle.
    task automatic waitDone;
        int n;
        n = 0;
        while (!done16 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done16) checkOutput("done_timeout", 32'(done16), 32'd1);
        @(negedge clk);
    endtask

    // Monitor for the 16-bit instance: result, latency, busy length, pulse width
    int   busy_cnt16;
    logic prev_done16;
    exp_t m16;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt16 = 0;
        end else begin
            if (done16) begin
                checkOutput("done_pulse", 32'(prev_done16), 32'd0);
                if (q16.size() == 0) begin
                    checkOutput("spurious_done16", 32'd1, 32'd0);
                end else begin
                    m16 = q16.pop_front();
                    checkOutput("sum16", 32'(sum16), m16.sum);
                    checkOutput("cout16", 32'(cout16), 32'(m16.cout));
                    checkOutput("ovf16", 32'(ovf16), 32'(m16.ovf));
                    checkOutput("latency16", 32'(cyc - m16.stamp), 32'd5);
                    checkOutput("busy_len16", 32'(busy_cnt16), 32'd4);
                end
                busy_cnt16 = 0;
            end
            if (busy16) busy_cnt16++;
        end
        prev_done16 = done16;
    end

    // Monitor for the 8-bit instance
    exp_t m8;
    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                checkOutput("spurious_done8", 32'd1, 32'd0);
            end else begin
                m8 = q8.pop_front();
                checkOutput("sum8", 32'(sum8), m8.sum);
                checkOutput("cout8", 32'(cout8), 32'(m8.cout));
                checkOutput("ovf8", 32'(ovf8), 32'(m8.ovf));
                checkOutput("latency8", 32'(cyc - m8.stamp), 32'd2);
            end
        end
    end

    // Monitor for the 32-bit instance
    exp_t m32;
    always @(negedge clk) begin
        if (rst_n && done32) begin
            if (q32.size() == 0) begin
                checkOutput("spurious_done32", 32'd1, 32'd0);
            end else begin
                m32 = q32.pop_front();
                checkOutput("sum32", sum32, m32.sum);
                checkOutput("cout32", 32'(cout32), 32'(m32.cout));
                checkOutput("ovf32", 32'(ovf32), 32'(m32.ovf));
                checkOutput("latency32", 32'(cyc - m32.stamp), 32'd33);
            end
        end
    end

    initial begin
        int n;
        exp_t e;
        checks = 0;
        errors = 0;
        cyc = 0;
        cur_sum = '0;
        prev_sum = '0;
        prev_done16 = 1'b0;
        busy_cnt16 = 0;
        rst_n = 1'b0;
        {start16, cin16, sub16, a16, b16} = '0;
        {start8, cin8, sub8, a8, b8} = '0;
        {start32, cin32, sub32, a32, b32} = '0;

        // Reset state
        #12;
        checkOutput("rst_busy", 32'(busy16), 32'd0);
        checkOutput("rst_done", 32'(done16), 32'd0);
        checkOutput("rst_sum", 32'(sum16), 32'd0);
        checkOutput("rst_cout", 32'(cout16), 32'd0);
        checkOutput("rst_ovf", 32'(ovf16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed arithmetic
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0); waitDone();
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0); waitDone();
        applyStimulus(16'h7FFF, 16'h0000, 1'b1, 1'b0); waitDone();
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1); waitDone();
        // cin is high here to show it is ignored in subtract mode
        applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b1); waitDone();

        // Protocol: start and operand changes during RUN and DONE are ignored
        applyStimulus(16'h0F0F, 16'h1111, 1'b0, 1'b0);
        a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b1; sub16 = 1'b1;
        start16 = 1'b1;
        checkOutput("sum_hold", 32'(sum16), 32'(prev_sum));
        @(negedge clk);
        start16 = 1'b0;
        n = 0;
        while (!done16 && n < 40) begin
            checkOutput("sum_hold", 32'(sum16), 32'(prev_sum));
            b16 = b16 + 16'h0101;
            @(negedge clk);
            n++;
        end
        if (!done16) checkOutput("done_timeout", 32'(done16), 32'd1);
        a16 = 16'h1357; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        checkOutput("start_in_done_ignored", 32'(busy16), 32'd0);
        @(negedge clk);

        // Back-to-back: waitDone returns in the IDLE cycle right after DONE
        applyStimulus(16'hC000, 16'h4000, 1'b0, 1'b0); waitDone();
        applyStimulus(16'h0100, 16'h0200, 1'b1, 1'b1); waitDone();

        // Asynchronous reset in the second RUN cycle
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy16), 32'd0);
        checkOutput("abort_done", 32'(done16), 32'd0);
        checkOutput("abort_sum", 32'(sum16), 32'd0);
        checkOutput("abort_cout", 32'(cout16), 32'd0);
        checkOutput("abort_ovf", 32'(ovf16), 32'd0);
        e = q16.pop_back();
        cur_sum = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0); waitDone();

        // Random operands on the single-chunk instance
        for (int i = 0; i < 20; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            cin8 = 1'($urandom); sub8 = 1'($urandom);
            start8 = 1'b1;
            q8.push_back(model(8, {24'd0, a8}, {24'd0, b8}, cin8, sub8, cyc));
            @(negedge clk);
            start8 = 1'b0;
            n = 0;
            while (!done8 && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (!done8) checkOutput("done8_timeout", 32'(done8), 32'd1);
            @(negedge clk);
        end

        // Random operands on the bit-serial instance
        for (int i = 0; i < 8; i++) begin
            a32 = $urandom; b32 = $urandom;
            cin32 = 1'($urandom); sub32 = 1'($urandom);
            if (i == 0) begin a32 = 32'hFFFF_FFFF; b32 = 32'd0; cin32 = 1'b1; sub32 = 1'b0; end
            start32 = 1'b1;
            q32.push_back(model(32, a32, b32, cin32, sub32, cyc));
            @(negedge clk);
            start32 = 1'b0;
            n = 0;
            while (!done32 && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (!done32) checkOutput("done32_timeout", 32'(done32), 32'd1);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        checkOutput("q16_drained", 32'(q16.size()), 32'd0);
        checkOutput("q8_drained", 32'(q8.size()), 32'd0);
        checkOutput("q32_drained", 32'(q32.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
